dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 146 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller with one word per line.
// A miss freezes the pipeline while the victim is written back, the line is refilled, and the access replays.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;
    localparam logic [1:0] S_UPDATE    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic             hit_s;
    logic             line_we_s;
    logic [31:0]      line_wdata_s;
    logic [31:0]      cpu_data_s;
    logic             cpu_stall_s;
    logic             mem_req_s;
    logic             mem_we_s;
    logic [31:0]      mem_addr_s;
    logic [31:0]      mem_data_s;
    logic             unused_s;

    assign idx_s    = cpu_addr_i[IDX_W+1:2];
    assign tag_s    = cpu_addr_i[31:IDX_W+2];
    assign hit_s    = cpu_req_i & valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    assign unused_s = ^cpu_addr_i[1:0];

    // Next-state, line update and raw output decode for the miss-handling FSM.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we_s    = 1'b0;
        line_wdata_s = cpu_data_i;
        cpu_data_s   = 32'h0;
        cpu_stall_s  = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = 32'h0;
        mem_data_s   = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (hit_s) begin
                    if (cpu_we_i) begin
                        line_we_s      = 1'b1;
                        dirty_d[idx_s] = 1'b1;
                    end else begin
                        cpu_data_s = data_q[idx_s];
                    end
                end else if (cpu_req_i) begin
                    cpu_stall_s = 1'b1;
                    state_d     = (valid_q[idx_s] & dirty_q[idx_s]) ? S_WRITEBACK : S_ALLOCATE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                cpu_stall_s = 1'b1;
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = {tag_q[idx_s], idx_s, 2'b00};
                mem_data_s  = data_q[idx_s];
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_ALLOCATE: begin
                cpu_stall_s = 1'b1;
                mem_req_s   = 1'b1;
                mem_addr_s  = {cpu_addr_i[31:2], 2'b00};
                if (mem_ack_i) begin
                    line_we_s      = 1'b1;
                    line_wdata_s   = mem_data_i;
                    valid_d[idx_s] = 1'b1;
                    dirty_d[idx_s] = 1'b0;
                    state_d        = S_UPDATE;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_UPDATE: begin
                cpu_stall_s = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset forces every output low, so an aborted request never reaches memory or the pipeline.
    assign cpu_data_o  = rst_i ? cpu_data_s  : 32'h0;
    assign cpu_stall_o = rst_i ? cpu_stall_s : 1'b0;
    assign mem_req_o   = rst_i ? mem_req_s   : 1'b0;
    assign mem_we_o    = rst_i ? mem_we_s    : 1'b0;
    assign mem_addr_o  = rst_i ? mem_addr_s  : 32'h0;
    assign mem_data_o  = rst_i ? mem_data_s  : 32'h0;

    // FSM state and per-line valid/dirty bits; reset invalidates every line.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays keep their contents through reset; writes are suppressed while it is held.
    always_ff @(posedge clk_i) begin
        if (line_we_s && rst_i) begin
            tag_q[idx_s]  <= tag_s;
            data_q[idx_s] <= line_wdata_s;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a small memory responder acks after a chosen number of request cycles.
module tb_dcache_ctrl;
    logic        clk;
    logic        rst_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    int checks = 0;
    int errors = 0;

    int          obs_stalls, obs_wb_n, obs_rd_n, obs_z_err;
    logic        obs_timeout, obs_first_we;
    logic [31:0] obs_rdata, obs_wb_addr, obs_wb_data, obs_rd_addr;

    dcache_ctrl #(.NUM_LINES(16), .IDX_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Holds one CPU access until the stall drops, acking each memory transaction in its k-th cycle.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] fill, input int k);
        int  cnt;
        bit  active;
        bit  done;
        cnt = 0; active = 1'b0; done = 1'b0;
        obs_stalls = 0; obs_wb_n = 0; obs_rd_n = 0; obs_z_err = 0;
        obs_timeout = 1'b0; obs_first_we = 1'b0; obs_rdata = 32'h0;
        obs_wb_addr = 32'h0; obs_wb_data = 32'h0; obs_rd_addr = 32'h0;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!mem_req_o && (mem_addr_o != 32'h0 || mem_data_o != 32'h0)) obs_z_err++;
            if (!cpu_stall_o) begin
                obs_rdata = cpu_data_o;
                done = 1'b1;
            end else begin
                obs_stalls++;
                if (mem_req_o) begin
                    cnt = active ? cnt + 1 : 1;
                    active = 1'b1;
                    if (cnt == k) begin
                        if (obs_wb_n + obs_rd_n == 0) obs_first_we = mem_we_o;
                        if (mem_we_o) begin
                            obs_wb_n++; obs_wb_addr = mem_addr_o; obs_wb_data = mem_data_o;
                        end else begin
                            obs_rd_n++; obs_rd_addr = mem_addr_o;
                        end
                        mem_ack_i = 1'b1; mem_data_i = fill; active = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
        end
        if (!done) obs_timeout = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
        cpu_data_i = 32'h0; mem_data_i = 32'h0; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        if ({cpu_stall_o, mem_req_o, mem_we_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {cpu_stall_o, mem_req_o, mem_we_o});
        end
        checks++;
        if ({cpu_data_o, mem_addr_o, mem_data_o} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {cpu_data_o, mem_addr_o, mem_data_o});
        end
        checks++;
        @(posedge clk); #1;
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk);
        if ({cpu_stall_o, mem_req_o, cpu_data_o, mem_addr_o} !== 66'h0) begin
            errors++; $display("FAIL idle_outputs: stall %b req %b data %h addr %h expected all 0",
                               cpu_stall_o, mem_req_o, cpu_data_o, mem_addr_o);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read();
        do_access(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 3);
        if (obs_timeout !== 1'b0) begin errors++; $display("FAIL cold_timeout: got %b expected 0", obs_timeout); end
        checks++;
        if (obs_stalls != 5) begin errors++; $display("FAIL cold_stall: got %0d expected 5", obs_stalls); end
        checks++;
        if (obs_rdata !== 32'h1234_5678) begin errors++; $display("FAIL cold_data: got %h expected 12345678", obs_rdata); end
        checks++;
        if (obs_rd_n != 1 || obs_wb_n != 0 || obs_rd_addr !== 32'h40) begin
            errors++; $display("FAIL cold_mem: rd %0d wb %0d addr %h expected 1 0 00000040", obs_rd_n, obs_wb_n, obs_rd_addr);
        end
        checks++;
        if (obs_z_err != 0) begin errors++; $display("FAIL cold_idle_bus: got %0d expected 0", obs_z_err); end
        checks++;
    endtask

    task automatic test_write_hit();
        do_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1);
        if (obs_stalls != 0 || obs_rd_n + obs_wb_n != 0) begin
            errors++; $display("FAIL wr_hit: stall %0d mem %0d expected 0 0", obs_stalls, obs_rd_n + obs_wb_n);
        end
        checks++;
        do_access(1'b0, 32'h0000_0040, 32'h0, 32'h0, 1);
        if (obs_stalls != 0 || obs_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_hit: stall %0d data %h expected 0 deadbeef", obs_stalls, obs_rdata);
        end
        checks++;
    endtask

    task automatic test_dirty_evict();
        do_access(1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 2);
        if (obs_wb_n != 1 || obs_wb_addr !== 32'h40 || obs_wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL evict_wb: n %0d addr %h data %h expected 1 00000040 deadbeef",
                               obs_wb_n, obs_wb_addr, obs_wb_data);
        end
        checks++;
        if (obs_first_we !== 1'b1 || obs_rd_n != 1 || obs_rd_addr !== 32'h80) begin
            errors++; $display("FAIL evict_rd: first_we %b n %0d addr %h expected 1 1 00000080",
                               obs_first_we, obs_rd_n, obs_rd_addr);
        end
        checks++;
        if (obs_stalls != 6 || obs_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL evict_stall: stall %0d data %h expected 6 cafef00d", obs_stalls, obs_rdata);
        end
        checks++;
    endtask

    task automatic test_zero_wait();
        // Evicting the freshly refilled 0x80 line must not write back: it is clean.
        do_access(1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222, 1);
        if (obs_wb_n != 0 || obs_stalls != 3 || obs_rdata !== 32'h1111_2222) begin
            errors++; $display("FAIL zero_wait: wb %0d stall %0d data %h expected 0 3 11112222",
                               obs_wb_n, obs_stalls, obs_rdata);
        end
        checks++;
        do_access(1'b0, 32'h0000_0104, 32'h0, 32'h5555_AAAA, 1);
        if (obs_stalls != 3 || obs_rdata !== 32'h5555_AAAA) begin
            errors++; $display("FAIL zero_wait2: stall %0d data %h expected 3 5555aaaa", obs_stalls, obs_rdata);
        end
        checks++;
    endtask

    task automatic test_reset_abort();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0208;
        @(posedge clk); #1;
        @(negedge clk);
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h208}) begin
            errors++; $display("FAIL abort_alloc: req %b we %b addr %h expected 1 0 00000208", mem_req_o, mem_we_o, mem_addr_o);
        end
        checks++;
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk);
        if ({mem_req_o, cpu_stall_o} !== 2'b00) begin
            errors++; $display("FAIL abort_drop: req %b stall %b expected 0 0", mem_req_o, cpu_stall_o);
        end
        checks++;
        @(posedge clk); #1;
        do_access(1'b0, 32'h0000_0208, 32'h0, 32'h7777_8888, 2);
        if (obs_stalls != 4 || obs_rd_n != 1 || obs_rdata !== 32'h7777_8888) begin
            errors++; $display("FAIL abort_remiss: stall %0d rd %0d data %h expected 4 1 77778888",
                               obs_stalls, obs_rd_n, obs_rdata);
        end
        checks++;
        do_access(1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 1);
        if (obs_stalls != 3 || obs_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL reset_invalidate: stall %0d data %h expected 3 0badf00d", obs_stalls, obs_rdata);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0102_0304, 1);
        if (obs_stalls != 3 || obs_rd_n != 1 || obs_rd_addr !== 32'h300) begin
            errors++; $display("FAIL wr_alloc: stall %0d rd %0d addr %h expected 3 1 00000300",
                               obs_stalls, obs_rd_n, obs_rd_addr);
        end
        checks++;
        do_access(1'b0, 32'h0000_0300, 32'h0, 32'h0, 1);
        if (obs_stalls != 0 || obs_rdata !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL wr_alloc_data: stall %0d data %h expected 0 a5a5a5a5", obs_stalls, obs_rdata);
        end
        checks++;
        do_access(1'b0, 32'h0000_0340, 32'h0, 32'h3434_3434, 1);
        if (obs_wb_n != 1 || obs_wb_addr !== 32'h300 || obs_wb_data !== 32'hA5A5_A5A5 || obs_stalls != 4) begin
            errors++; $display("FAIL wr_alloc_evict: wb %0d addr %h data %h stall %0d expected 1 00000300 a5a5a5a5 4",
                               obs_wb_n, obs_wb_addr, obs_wb_data, obs_stalls);
        end
        checks++;
        if (obs_rdata !== 32'h3434_3434) begin
            errors++; $display("FAIL wr_alloc_evict_data: got %h expected 34343434", obs_rdata);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_evict();
        test_zero_wait();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
